trap_sequencer: RTL and testbench

- Arbitrates synchronous exceptions, xRET requests and pending interrupts at the WB boundary.
- Picks one winner per decision and sequences the pipeline flush.
- Issues a single commit pulse to the CSR file (trap entry or xRET), then holds the pipeline until fetch acknowledges the redirect.
- Sits between the WB stage, the CSR handler/file and the hazard unit; it is the only source of CSR trap commits and of flush == 2'b11.

---
 rtl/trap_sequencer_pkg.sv | 41 ++++
 rtl/irq_priority_encoder.sv | 36 +++
 rtl/trap_sequencer.sv | 171 +++++++++++++++++
 tb/tb_trap_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: FSM states, interrupt bit map,
// privilege and flush encodings, and the interrupt takeability rule.
package csr_defs;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_COMMIT   = 2'd2,
      ST_REDIRECT = 2'd3
   } state_e;

   localparam int IRQ_SSI = 1;
   localparam int IRQ_MSI = 3;
   localparam int IRQ_STI = 5;
   localparam int IRQ_MTI = 7;
   localparam int IRQ_SEI = 9;
   localparam int IRQ_MEI = 11;
   localparam int IRQ_NUM = 6;

   // Highest priority first
   localparam logic [3:0] IRQ_ORDER [IRQ_NUM] = '{
      4'(IRQ_MEI), 4'(IRQ_MSI), 4'(IRQ_MTI), 4'(IRQ_SEI), 4'(IRQ_SSI), 4'(IRQ_STI)
   };

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_M = 2'b11;

   localparam logic [1:0] FLUSH_NONE = 2'b00;
   localparam logic [1:0] FLUSH_ALL  = 2'b11;

   // Delegated interrupts can never preempt M-mode.
   function automatic logic irq_takeable(input logic deleg, input logic [1:0] priv,
                                         input logic mie, input logic sie);
      if (deleg)
         return (priv == PRIV_U) || ((priv == PRIV_S) && sie);
      else
         return (priv != PRIV_M) || mie;
   endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Picks the highest-priority pending, enabled and takeable interrupt and
// reports its cause and whether it is handled in S-mode.
module irq_priority_encoder
   import csr_defs::*;
(
   input  logic [11:0] i_pending,
   input  logic [11:0] i_enable,
   input  logic [11:0] i_deleg,
   input  logic [1:0]  i_priv,
   input  logic        i_mie,
   input  logic        i_sie,
   output logic        o_valid,
   output logic [4:0]  o_cause,
   output logic        o_to_s
);

   logic [11:0] w_cand;

   assign w_cand = i_pending & i_enable;

   // Walk from lowest to highest priority so the last hit wins.
   always_comb begin
      o_valid = 1'b0;
      o_cause = 5'd0;
      o_to_s  = 1'b0;
      for (int k = IRQ_NUM - 1; k >= 0; k--) begin
         if (w_cand[IRQ_ORDER[k]] &&
             irq_takeable(i_deleg[IRQ_ORDER[k]], i_priv, i_mie, i_sie)) begin
            o_valid = 1'b1;
            o_cause = {1'b0, IRQ_ORDER[k]};
            o_to_s  = i_deleg[IRQ_ORDER[k]];
         end
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// WB-boundary trap/xRET arbiter: captures one winner, flushes, commits once to
// the CSR file, then stalls until fetch acknowledges the redirect.
module trap_sequencer
   import csr_defs::*;
#(
   parameter int FLUSH_CYCLES     = 2,
   parameter int REDIRECT_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_valid,
   input  logic [4:0]  exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic        xret_valid,
   input  logic        xret_is_mret,
   input  logic        inst_retire,
   input  logic [31:0] wb_pc,
   input  logic [11:0] irq_pending,
   input  logic [11:0] irq_enable,
   input  logic [11:0] mideleg,
   input  logic [15:0] medeleg,
   input  logic        mstatus_mie,
   input  logic        mstatus_sie,
   input  logic [1:0]  priv,
   input  logic        redirect_ack,
   output logic [1:0]  flush,
   output logic        stall,
   output logic        trap_take,
   output logic        trap_is_irq,
   output logic        trap_to_s,
   output logic [4:0]  trap_cause,
   output logic [31:0] trap_epc,
   output logic [31:0] trap_tval,
   output logic        xret_take,
   output logic        xret_mret,
   output logic        busy,
   output logic        timeout_err
);

   localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] TMO_LAST = 8'(REDIRECT_TIMEOUT - 1);

   state_e      r_state, w_state_nxt;
   logic [2:0]  r_cnt;
   logic [7:0]  r_tmo;
   logic        r_is_xret, r_is_irq, r_to_s, r_mret, r_timeout_err;
   logic [4:0]  r_cause;
   logic [31:0] r_epc, r_tval;

   logic        w_irq_valid, w_irq_to_s, w_exc_to_s;
   logic [4:0]  w_irq_cause;
   logic        w_cap_exc, w_cap_xret, w_cap_irq, w_tmo_hit;

   irq_priority_encoder u_irq_enc (
      .i_pending (irq_pending),
      .i_enable  (irq_enable),
      .i_deleg   (mideleg),
      .i_priv    (priv),
      .i_mie     (mstatus_mie),
      .i_sie     (mstatus_sie),
      .o_valid   (w_irq_valid),
      .o_cause   (w_irq_cause),
      .o_to_s    (w_irq_to_s)
   );

   // Causes >= 16 have no medeleg bit and always trap to M.
   assign w_exc_to_s = !exc_cause[4] && medeleg[exc_cause[3:0]] && (priv != PRIV_M);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cap_exc   = 1'b0;
      w_cap_xret  = 1'b0;
      w_cap_irq   = 1'b0;
      w_tmo_hit   = 1'b0;
      flush       = FLUSH_NONE;
      stall       = 1'b1;
      busy        = 1'b1;
      trap_take   = 1'b0;
      xret_take   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            stall = 1'b0;
            busy  = 1'b0;
            if (exc_valid) begin
               w_cap_exc   = 1'b1;
               w_state_nxt = ST_FLUSH;
            end else if (xret_valid) begin
               w_cap_xret  = 1'b1;
               w_state_nxt = ST_FLUSH;
            end else if (inst_retire && w_irq_valid) begin
               w_cap_irq   = 1'b1;
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            flush = FLUSH_ALL;
            if (r_cnt == 3'd0) w_state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            trap_take   = !r_is_xret;
            xret_take   = r_is_xret;
            w_state_nxt = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            if (redirect_ack) begin
               w_state_nxt = ST_IDLE;
            end else if (r_tmo == TMO_LAST) begin
               w_tmo_hit   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt         <= 3'd0;
         r_tmo         <= 8'd0;
         r_is_xret     <= 1'b0;
         r_is_irq      <= 1'b0;
         r_to_s        <= 1'b0;
         r_mret        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_cause       <= 5'd0;
         r_epc         <= 32'd0;
         r_tval        <= 32'd0;
      end else begin
         if (r_state != ST_FLUSH)  r_cnt <= CNT_LOAD;
         else if (r_cnt != 3'd0)   r_cnt <= r_cnt - 3'd1;
         if (r_state != ST_REDIRECT) r_tmo <= 8'd0;
         else                        r_tmo <= r_tmo + 8'd1;
         if (w_tmo_hit) r_timeout_err <= 1'b1;
         if (w_cap_exc) begin
            r_is_xret <= 1'b0;
            r_is_irq  <= 1'b0;
            r_to_s    <= w_exc_to_s;
            r_cause   <= exc_cause;
            r_epc     <= exc_pc;
            r_tval    <= exc_tval;
         end
         if (w_cap_irq) begin
            r_is_xret <= 1'b0;
            r_is_irq  <= 1'b1;
            r_to_s    <= w_irq_to_s;
            r_cause   <= w_irq_cause;
            r_epc     <= wb_pc + 32'd4;
            r_tval    <= 32'd0;
         end
         if (w_cap_xret) begin
            r_is_xret <= 1'b1;
            r_mret    <= xret_is_mret;
         end
      end
   end

   assign trap_is_irq = r_is_irq;
   assign trap_to_s   = r_to_s;
   assign trap_cause  = r_cause;
   assign trap_epc    = r_epc;
   assign trap_tval   = r_tval;
   assign xret_mret   = r_mret;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus randomized requests,
// each checked against a behavioural model of the arbitration rules.
module tb_trap_sequencer;

   localparam int FC  = 2;
   localparam int TMO = 15;
   localparam logic [1:0] K_NONE = 2'd0, K_EXC = 2'd1, K_XRET = 2'd2, K_IRQ = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [4:0]  cause;
      logic        is_irq;
      logic        to_s;
      logic [31:0] epc;
      logic [31:0] tval;
      logic        mret;
   } exp_t;

   logic        clk, rst;
   logic        exc_valid, xret_valid, xret_is_mret, inst_retire;
   logic [4:0]  exc_cause;
   logic [31:0] exc_pc, exc_tval, wb_pc;
   logic [11:0] irq_pending, irq_enable, mideleg;
   logic [15:0] medeleg;
   logic        mstatus_mie, mstatus_sie, redirect_ack;
   logic [1:0]  priv;
   logic [1:0]  flush;
   logic        stall, trap_take, trap_is_irq, trap_to_s, xret_take, xret_mret, busy, timeout_err;
   logic [4:0]  trap_cause;
   logic [31:0] trap_epc, trap_tval;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   logic exp_tmo = 1'b0;

   trap_sequencer #(.FLUSH_CYCLES(FC), .REDIRECT_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .xret_valid(xret_valid), .xret_is_mret(xret_is_mret),
      .inst_retire(inst_retire), .wb_pc(wb_pc),
      .irq_pending(irq_pending), .irq_enable(irq_enable), .mideleg(mideleg), .medeleg(medeleg),
      .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie), .priv(priv),
      .redirect_ack(redirect_ack),
      .flush(flush), .stall(stall), .trap_take(trap_take), .trap_is_irq(trap_is_irq),
      .trap_to_s(trap_to_s), .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
      .xret_take(xret_take), .xret_mret(xret_mret), .busy(busy), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      exc_valid   = 1'b0;
      xret_valid  = 1'b0;
      inst_retire = 1'b0;
   endtask

   // Winner selection straight from the priority rules.
   function automatic exp_t model();
      exp_t e;
      int   order [6] = '{11, 3, 7, 9, 1, 5};
      logic ok;
      e = '0;
      if (exc_valid) begin
         e.kind  = K_EXC;
         e.cause = exc_cause;
         e.to_s  = (int'(exc_cause) < 16) && medeleg[exc_cause[3:0]] && (priv != 2'b11);
         e.epc   = exc_pc;
         e.tval  = exc_tval;
      end else if (xret_valid) begin
         e.kind = K_XRET;
         e.mret = xret_is_mret;
      end else if (inst_retire) begin
         for (int i = 0; i < 6; i++) begin
            int b;
            b = order[i];
            if (!(irq_pending[b] && irq_enable[b])) continue;
            if (mideleg[b]) ok = (priv == 2'b00) || (priv == 2'b01 && mstatus_sie);
            else            ok = (priv != 2'b11) || mstatus_mie;
            if (ok) begin
               e.kind   = K_IRQ;
               e.cause  = 5'(b);
               e.is_irq = 1'b1;
               e.to_s   = mideleg[b];
               e.epc    = wb_pc + 32'd4;
               e.tval   = 32'd0;
               break;
            end
         end
      end
      return e;
   endfunction

   // Presents the currently driven request for one edge and follows it to IDLE.
   task automatic do_txn(input int ack_dly);
      exp_t e;
      e = model();
      tick();
      clear_req();
      if (e.kind == K_NONE) begin
         chk("no_req_busy", 32'(busy), 32'd0);
         chk("no_req_take", 32'({trap_take, xret_take}), 32'd0);
         return;
      end
      for (int i = 0; i < FC; i++) begin
         chk("flush_val", 32'(flush), 32'd3);
         chk("flush_stall", 32'(stall), 32'd1);
         chk("flush_take", 32'({trap_take, xret_take}), 32'd0);
         tick();
      end
      chk("commit_flush", 32'(flush), 32'd0);
      chk("commit_trap_take", 32'(trap_take), 32'(e.kind != K_XRET));
      chk("commit_xret_take", 32'(xret_take), 32'(e.kind == K_XRET));
      if (e.kind == K_XRET) begin
         chk("xret_mret", 32'(xret_mret), 32'(e.mret));
      end else begin
         chk("trap_is_irq", 32'(trap_is_irq), 32'(e.is_irq));
         chk("trap_to_s", 32'(trap_to_s), 32'(e.to_s));
         chk("trap_cause", 32'(trap_cause), 32'(e.cause));
         chk("trap_epc", trap_epc, e.epc);
         chk("trap_tval", trap_tval, e.tval);
      end
      tick();
      for (int i = 0; i < ack_dly && i < TMO; i++) begin
         chk("redir_stall", 32'(stall), 32'd1);
         chk("redir_take", 32'({trap_take, xret_take}), 32'd0);
         tick();
      end
      if (ack_dly >= TMO) begin
         exp_tmo = 1'b1;
         chk("tmo_busy", 32'(busy), 32'd0);
      end else begin
         redirect_ack = 1'b1;
         tick();
         redirect_ack = 1'b0;
         chk("ack_busy", 32'(busy), 32'd0);
         chk("ack_stall", 32'(stall), 32'd0);
      end
      chk("timeout_err", 32'(timeout_err), 32'(exp_tmo));
   endtask

   initial begin
      rst = 1'b0;
      clear_req();
      exc_cause = '0; exc_pc = '0; exc_tval = '0; xret_is_mret = 1'b0; wb_pc = '0;
      irq_pending = '0; irq_enable = '0; mideleg = '0; medeleg = '0;
      mstatus_mie = 1'b0; mstatus_sie = 1'b0; priv = 2'b00; redirect_ack = 1'b0;
      tick();
      tick();
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_take", 32'({trap_take, xret_take}), 32'd0);
      chk("rst_epc", trap_epc, 32'd0);
      chk("rst_tmo", 32'(timeout_err), 32'd0);
      rst = 1'b1;
      tick();

      // Illegal instruction in U
      exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h8000_0010; exc_tval = 32'd0;
      do_txn(3);

      // MTI in U
      irq_pending = 12'h080; irq_enable = 12'h080; inst_retire = 1'b1; wb_pc = 32'h1000;
      do_txn(1);

      // Priority among MSI/MTI/MEI
      irq_pending = 12'h888; irq_enable = 12'hFFF; inst_retire = 1'b1;
      do_txn(0);

      // Delegated SEI while in M: not takeable
      irq_pending = 12'h200; mideleg = 12'h200; priv = 2'b11; mstatus_mie = 1'b0; inst_retire = 1'b1;
      do_txn(0);

      // Exception + xRET + MEI together; MEI follows on the next retire
      irq_pending = 12'h800; mideleg = '0; mstatus_mie = 1'b1;
      exc_valid = 1'b1; exc_cause = 5'd11; exc_pc = 32'h2000; exc_tval = 32'h1234;
      xret_valid = 1'b1; inst_retire = 1'b1;
      do_txn(2);
      inst_retire = 1'b1; wb_pc = 32'hFFFF_FFFC;
      do_txn(2);

      // MRET
      irq_pending = '0;
      xret_valid = 1'b1; xret_is_mret = 1'b1;
      do_txn(1);

      for (int n = 0; n < 40; n++) begin
         int p;
         p = int'($urandom_range(0, 2));
         priv         = (p == 2) ? 2'b11 : 2'(p);
         mstatus_mie  = 1'($urandom);
         mstatus_sie  = 1'($urandom);
         irq_pending  = 12'($urandom);
         irq_enable   = 12'($urandom);
         mideleg      = 12'($urandom);
         medeleg      = 16'($urandom);
         exc_valid    = ($urandom_range(0, 2) == 0);
         exc_cause    = 5'($urandom);
         exc_pc       = $urandom;
         exc_tval     = $urandom;
         xret_valid   = ($urandom_range(0, 3) == 0);
         xret_is_mret = 1'($urandom);
         inst_retire  = 1'($urandom);
         wb_pc        = $urandom;
         do_txn(int'($urandom_range(0, 5)));
      end

      // Redirect timeout
      exc_valid = 1'b1; exc_cause = 5'd4; exc_pc = 32'h3000; exc_tval = 32'h5;
      do_txn(TMO + 5);

      // Reset asserted mid-flush
      exc_valid = 1'b1;
      tick();
      clear_req();
      chk("pre_rst_flush", 32'(flush), 32'd3);
      rst = 1'b0;
      #1;
      chk("arst_flush", 32'(flush), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_tmo", 32'(timeout_err), 32'd0);
      chk("arst_cause", 32'(trap_cause), 32'd0);
      tick();
      rst = 1'b1;
      exp_tmo = 1'b0;
      tick();
      exc_valid = 1'b1; exc_cause = 5'd13; exc_pc = 32'h4000; exc_tval = 32'h77;
      do_txn(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
